// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler and its arbiter.
// Address width matches the core instruction memory.
package warp_scheduler_pkg;

  localparam int IMEM_AW = 16;

  typedef logic [IMEM_AW-1:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    READY,
    ISSUED,
    DONE
  } warp_state_t;

  function automatic int widx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Issue/retire bundle between the scheduler and the shared pipeline.
// master = scheduler side, slave = pipeline side.
interface warp_scheduler_if
  import warp_scheduler_pkg::*;
#(
  parameter int W = 2
);

  localparam int IW = widx_w(W);

  logic                        issue_valid;
  logic [IW-1:0]               issue_warp;
  instruction_memory_address_t issue_pc;
  logic                        issue_ready;

  logic                        retire_valid;
  logic [IW-1:0]               retire_warp;
  instruction_memory_address_t retire_next_pc;
  logic                        retire_halt;

  modport master (
    output issue_valid,
    output issue_warp,
    output issue_pc,
    input  issue_ready,
    input  retire_valid,
    input  retire_warp,
    input  retire_next_pc,
    input  retire_halt
  );

  modport slave (
    input  issue_valid,
    input  issue_warp,
    input  issue_pc,
    output issue_ready,
    output retire_valid,
    output retire_warp,
    output retire_next_pc,
    output retire_halt
  );

endinterface

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly
// after ptr wins, wrapping. One-hot grant plus index.
module warp_scheduler_rr_arbiter
  import warp_scheduler_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = widx_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] &&
            j == (int'(ptr) + i) % N) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: launches warps, tracks fetch/issue/
// retire per warp and offers READY warps round-robin.
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int WARPS_PER_CORE   = 2,
  parameter int THREADS_PER_WARP = 32
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(WARPS_PER_CORE):0] num_warps,
  input  instruction_memory_address_t base_pc,
  output logic                        done,
  output logic [WARPS_PER_CORE-1:0]   fetch_req_valid,
  output instruction_memory_address_t fetch_pc [WARPS_PER_CORE],
  input  logic [WARPS_PER_CORE-1:0]   fetch_done,
  warp_scheduler_if.master            pipe,
  output logic                        protocol_error
);

  localparam int W  = WARPS_PER_CORE;
  localparam int IW = widx_w(W);

  if (W < 1 || W > 16 || THREADS_PER_WARP < 1) begin : g_bad_cfg
    $error("warp_scheduler: bad configuration");
  end

  warp_state_t                 state_q [W];
  warp_state_t                 state_d [W];
  instruction_memory_address_t pc_q    [W];
  instruction_memory_address_t pc_d    [W];

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] lock_q, lock_d;
  logic          lock_vld_q, lock_vld_d;
  logic          done_d, perr_d;

  logic [W-1:0]  ready_vec, grant;
  logic [IW-1:0] gidx;
  logic          running, all_done;
  logic          accept, fire, hit;

  always_comb begin
    running  = 1'b0;
    all_done = 1'b1;
    for (int w = 0; w < W; w++) begin
      ready_vec[w]       = state_q[w] == READY;
      fetch_req_valid[w] = state_q[w] == FETCH;
      fetch_pc[w]        = pc_q[w];
      if (state_q[w] != IDLE && state_q[w] != DONE)
        running = 1'b1;
      if (state_q[w] != DONE)
        all_done = 1'b0;
    end
  end

  warp_scheduler_rr_arbiter #(.N(W)) u_arb (
    .req   (ready_vec),
    .ptr   (rr_q),
    .grant (grant),
    .idx   (gidx)
  );

  assign accept = start && !running;
  assign fire   = lock_vld_q && pipe.issue_ready;

  assign pipe.issue_valid = lock_vld_q;
  assign pipe.issue_warp  = lock_vld_q ? lock_q : '0;
  assign pipe.issue_pc    = lock_vld_q ? pc_q[lock_q] : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_vld_d = lock_vld_q;
    hit        = 1'b0;

    for (int w = 0; w < W; w++) begin
      if (state_q[w] == FETCH && fetch_done[w])
        state_d[w] = READY;
      if (fire && lock_q == IW'(w))
        state_d[w] = ISSUED;
      if (pipe.retire_valid &&
          pipe.retire_warp == IW'(w) &&
          state_q[w] == ISSUED) begin
        hit = 1'b1;
        if (pipe.retire_halt) begin
          state_d[w] = DONE;
        end else begin
          state_d[w] = FETCH;
          pc_d[w]    = pipe.retire_next_pc;
        end
      end
    end

    // lock is released on handshake; reselect on a later cycle
    if (fire) begin
      rr_d       = lock_q;
      lock_vld_d = 1'b0;
    end else if (!lock_vld_q && |grant) begin
      lock_vld_d = 1'b1;
      lock_d     = gidx;
    end

    if (accept) begin
      for (int w = 0; w < W; w++) begin
        if (w < int'(num_warps)) begin
          state_d[w] = FETCH;
          pc_d[w]    = base_pc;
        end else begin
          state_d[w] = DONE;
        end
      end
    end

    perr_d = protocol_error | (pipe.retire_valid & ~hit);
    done_d = accept ? 1'b0 : all_done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < W; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
      end
      rr_q           <= IW'(W - 1);
      lock_q         <= '0;
      lock_vld_q     <= 1'b0;
      done           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      rr_q           <= rr_d;
      lock_q         <= lock_d;
      lock_vld_q     <= lock_vld_d;
      done           <= done_d;
      protocol_error <= perr_d;
    end
  end

endmodule
